// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA definitions: default 640x480 timing, the decoder's FSM state
// encoding, and the coordinate/colour types used on the decoder interface.
package vga_sync_decoder_pkg;

  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_H_TOTAL     = 800;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_V_TOTAL     = 525;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Bundle between a VGA timing source (master) and the sync decoder (slave).
//   master drives : hsync, vsync (active low), rgb, probe_col, probe_row
//   slave drives  : col, row, de, rgb_out, frame_start, locked,
//                   probe_rgb, probe_hit, err_cnt
interface vga_sync_decoder_if;
  import vga_sync_decoder_pkg::*;

  logic       hsync;
  logic       vsync;
  rgb_t       rgb;
  coord_t     probe_col;
  coord_t     probe_row;
  coord_t     col;
  coord_t     row;
  logic       de;
  rgb_t       rgb_out;
  logic       frame_start;
  logic       locked;
  rgb_t       probe_rgb;
  logic       probe_hit;
  logic [7:0] err_cnt;

  modport master (
    output hsync, vsync, rgb, probe_col, probe_row,
    input  col, row, de, rgb_out, frame_start, locked, probe_rgb, probe_hit, err_cnt
  );

  modport slave (
    input  hsync, vsync, rgb, probe_col, probe_row,
    output col, row, de, rgb_out, frame_start, locked, probe_rgb, probe_hit, err_cnt
  );

endinterface

// File: rtl/vga_sync_decoder_sync_edge_counter.sv
// Falling-edge detector on an active-low sync plus a saturating counter.
//   clk, rst : clock, synchronous active-high reset
//   sync_in  : sync level, same clock domain (no synchroniser)
//   clr      : load 0 this cycle (wins over inc)
//   inc      : advance by one, saturating at all-ones
//   fall     : 1->0 transition against the previous-cycle sample
//   cnt      : registered count
//   cnt_nxt  : count that belongs to the current input sample
module vga_sync_decoder_sync_edge_counter
  import vga_sync_decoder_pkg::*;
#(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_in,
  input  logic         clr,
  input  logic         inc,
  output logic         fall,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  logic sync_prev;

  assign fall = sync_prev & ~sync_in;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)
      cnt_nxt = '0;
    else if (inc)
      cnt_nxt = sat_inc(cnt);
  end

  // sample register: previous sync level and count
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_prev <= 1'b1;
      cnt       <= '0;
    end else begin
      sync_prev <= sync_in;
      cnt       <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder. Recovers col/row, the display-enable
// window and frame boundaries from hsync/vsync, qualifies the timing over
// LOCK_FRAMES conforming frames, counts timing errors while locked, and
// captures the pixel at a programmable probe coordinate.
//   vga_clk : pixel clock
//   rst     : synchronous active-high reset
//   bus     : slave side of vga_sync_decoder_if (syncs/rgb/probe in,
//             col/row/de/rgb_out/frame_start/locked/probe/err_cnt out)
// All outputs are registered, one cycle after the input sample.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int H_TOTAL     = VGA_H_TOTAL,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int V_TOTAL     = VGA_V_TOTAL,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input logic               vga_clk,
  input logic               rst,
  vga_sync_decoder_if.slave bus
);

  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic        h_fall, v_fall, vpend, frame_evt;
  logic [10:0] h_cnt, h_nxt;
  logic [9:0]  v_cnt, v_nxt;

  // A frame begins on the first hsync fall at or after a vsync fall.
  assign frame_evt = h_fall & (vpend | v_fall);

  vga_sync_decoder_sync_edge_counter #(.W(11)) u_h_cnt (
    .clk     (vga_clk),
    .rst     (rst),
    .sync_in (bus.hsync),
    .clr     (h_fall),
    .inc     (1'b1),
    .fall    (h_fall),
    .cnt     (h_cnt),
    .cnt_nxt (h_nxt)
  );

  vga_sync_decoder_sync_edge_counter #(.W(10)) u_v_cnt (
    .clk     (vga_clk),
    .rst     (rst),
    .sync_in (bus.vsync),
    .clr     (frame_evt),
    .inc     (h_fall),
    .fall    (v_fall),
    .cnt     (v_cnt),
    .cnt_nxt (v_nxt)
  );

  state_t     state;
  logic [7:0] good_frames;
  logic       frame_bad;
  logic [7:0] err_cnt_p1;

  logic   line_ok, frame_ok, conform, lock_evt, err_evt, lock_nxt, in_win;
  logic   vld_p0, hit_p0;
  coord_t col_p0, row_p0;

  // h_cnt/v_cnt still hold the last value of the ending line/frame here,
  // so the lengths are count + 1.
  assign line_ok  = ({1'b0, h_cnt} + 12'd1) == 12'(H_TOTAL);
  assign frame_ok = ({1'b0, v_cnt} + 11'd1) == 11'(V_TOTAL);
  assign conform  = frame_evt & ~frame_bad & line_ok & frame_ok;
  assign lock_evt = (state == MEASURE) & conform &
                    ((good_frames + 8'd1) >= 8'(LOCK_FRAMES));
  assign err_evt  = (state == LOCKED) &
                    ((h_fall & ~line_ok) | (frame_evt & ~frame_ok));
  // Lock status for this sample; de and locked follow it with no extra lag.
  assign lock_nxt = ((state == LOCKED) & ~err_evt) | lock_evt;

  assign in_win = (h_nxt >= 11'(H_START)) && (h_nxt < 11'(H_START + H_ACTIVE)) &&
                  (v_nxt >= 10'(V_START)) && (v_nxt < 10'(V_START + V_ACTIVE));
  assign col_p0 = coord_t'(h_nxt - 11'(H_START));
  assign row_p0 = coord_t'(v_nxt - 10'(V_START));
  assign vld_p0 = lock_nxt & in_win;
  assign hit_p0 = vld_p0 && (col_p0 == bus.probe_col) && (row_p0 == bus.probe_row);

  coord_t col_p1, row_p1;
  rgb_t   rgb_p1, probe_rgb_p1;
  logic   vld_p1, fs_p1, locked_p1, hit_p1;

  // p0 -> p1: FSM, error counter and registered outputs
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      state        <= SEARCH;
      good_frames  <= '0;
      frame_bad    <= 1'b0;
      vpend        <= 1'b0;
      err_cnt_p1   <= '0;
      col_p1       <= '0;
      row_p1       <= '0;
      rgb_p1       <= '0;
      vld_p1       <= 1'b0;
      fs_p1        <= 1'b0;
      locked_p1    <= 1'b0;
      hit_p1       <= 1'b0;
      probe_rgb_p1 <= '0;
    end else begin
      vpend <= ~h_fall & (vpend | v_fall);
      case (state)
        SEARCH: begin
          if (frame_evt) begin
            state       <= MEASURE;
            good_frames <= '0;
            frame_bad   <= 1'b0;
          end
        end
        MEASURE: begin
          if (frame_evt) begin
            frame_bad <= 1'b0;
            if (lock_evt) begin
              state       <= LOCKED;
              good_frames <= '0;
            end else if (conform) begin
              good_frames <= good_frames + 8'd1;
            end else begin
              good_frames <= '0;
            end
          end else if (h_fall && !line_ok) begin
            frame_bad <= 1'b1;
          end
        end
        LOCKED: begin
          if (err_evt) begin
            state      <= SEARCH;
            err_cnt_p1 <= sat_inc8(err_cnt_p1);
          end
        end
        default: state <= SEARCH;
      endcase
      locked_p1 <= lock_nxt;
      vld_p1    <= vld_p0;
      col_p1    <= col_p0;
      row_p1    <= row_p0;
      rgb_p1    <= vld_p0 ? bus.rgb : '0;
      fs_p1     <= frame_evt;
      hit_p1    <= hit_p0;
      if (hit_p0)
        probe_rgb_p1 <= bus.rgb;
    end
  end

  assign bus.col         = col_p1;
  assign bus.row         = row_p1;
  assign bus.de          = vld_p1;
  assign bus.rgb_out     = rgb_p1;
  assign bus.frame_start = fs_p1;
  assign bus.locked      = locked_p1;
  assign bus.probe_rgb   = probe_rgb_p1;
  assign bus.probe_hit   = hit_p1;
  assign bus.err_cnt     = err_cnt_p1;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced timing (20x12 clocks
// per frame, 10x6 visible) so that locking and relocking stay short.
module tb_vga_sync_decoder;
  import vga_sync_decoder_pkg::*;

  localparam int HS = 4, HB = 3, HA = 10, HT = 20;
  localparam int VS = 2, VB = 2, VA = 6,  VT = 12;

  logic vga_clk = 1'b0;
  logic rst     = 1'b1;

  vga_sync_decoder_if bus ();

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  always #5 vga_clk = ~vga_clk;

  int errors = 0;
  int checks = 0;

  // Timing generator state: position of the next sample and of the last one driven.
  int gh = 0, gv = 0, cur_h = 0, cur_v = 0;
  int stretch_line = -1;
  bit drop_frame   = 1'b0;
  bit tie_high     = 1'b1;

  function automatic logic [11:0] pix(input int h, input int v);
    return {v[5:0], h[5:0]};
  endfunction

  // Drive one sample at negedge, then return #1 after the posedge that
  // registers it, so outputs reflect the sample at (cur_h, cur_v).
  task automatic step();
    int len, lines;
    @(negedge vga_clk);
    bus.hsync = tie_high ? 1'b1 : (gh >= HS);
    bus.vsync = tie_high ? 1'b1 : (gv >= VS);
    bus.rgb   = pix(gh, gv);
    cur_h = gh;
    cur_v = gv;
    len   = (gv == stretch_line) ? HT + 1 : HT;
    lines = drop_frame ? VT - 1 : VT;
    gh++;
    if (gh == len) begin
      gh = 0;
      if (gv == stretch_line) stretch_line = -1;
      gv++;
      if (gv == lines) begin
        gv = 0;
        drop_frame = 1'b0;
      end
    end
    @(posedge vga_clk);
    #1;
  endtask

  task automatic run_to_fs(output bit got, output logic pre_locked);
    got = 1'b0;
    pre_locked = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      pre_locked = bus.locked;
      step();
      got = bus.frame_start;
    end
    checks++; if (!got) begin errors++; $display("FAIL fs_timeout: frame_start=0 after 400 cycles, expected 1"); end
  endtask

  task automatic test_relock(input string tag);
    bit got;
    logic pre;
    for (int k = 1; k <= 3; k++) begin
      run_to_fs(got, pre);
      checks++; if (bus.locked !== (k == 3)) begin errors++; $display("FAIL %s_relock_fs%0d: locked=%0b expected %0b", tag, k, bus.locked, (k == 3)); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tie_high = 1'b1;
    repeat (3) step();
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.de !== 1'b0) begin errors++; $display("FAIL reset_de: got %0b expected 0", bus.de); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", bus.err_cnt); end
    checks++; if ({bus.col, bus.row} !== 20'd0) begin errors++; $display("FAIL reset_colrow: got %0d,%0d expected 0,0", bus.col, bus.row); end
    checks++; if ({bus.probe_rgb, bus.rgb_out, bus.frame_start, bus.probe_hit} !== 26'd0) begin errors++; $display("FAIL reset_misc: probe_rgb=%0h rgb_out=%0h fs=%0b hit=%0b expected 0", bus.probe_rgb, bus.rgb_out, bus.frame_start, bus.probe_hit); end
  endtask

  task automatic test_lock();
    int n_lk = 0, n_de = 0;
    gh = 0; gv = 0;
    tie_high = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL lock_first_fs: frame_start=%0b expected 1", bus.frame_start); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_first_locked: locked=%0b expected 0", bus.locked); end
    for (int i = 1; i < 2 * HT * VT; i++) begin
      step();
      if (bus.locked) n_lk++;
      if (bus.de) n_de++;
    end
    checks++; if (n_lk != 0) begin errors++; $display("FAIL lock_early: locked high for %0d cycles expected 0", n_lk); end
    checks++; if (n_de != 0) begin errors++; $display("FAIL de_unlocked: de high for %0d cycles expected 0", n_de); end
    step();
    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_third_fs: locked=%0b expected 1", bus.locked); end
    checks++; if (bus.frame_start !== 1'b1) begin errors++; $display("FAIL lock_third_fs_pulse: frame_start=%0b expected 1", bus.frame_start); end
  endtask

  task automatic test_display_probe();
    int hits = 0;
    bit exp_de;
    bus.probe_col = 10'd3;
    bus.probe_row = 10'd2;
    for (int i = 1; i < HT * VT; i++) begin
      step();
      exp_de = (cur_h >= HS + HB) && (cur_h < HS + HB + HA) && (cur_v >= VS + VB) && (cur_v < VS + VB + VA);
      checks++; if (bus.de !== exp_de) begin errors++; $display("FAIL de @%0d,%0d: got %0b expected %0b", cur_h, cur_v, bus.de, exp_de); end
      if (exp_de) begin
        checks++; if (bus.col !== 10'(cur_h - (HS + HB))) begin errors++; $display("FAIL col @%0d,%0d: got %0d expected %0d", cur_h, cur_v, bus.col, cur_h - (HS + HB)); end
        checks++; if (bus.row !== 10'(cur_v - (VS + VB))) begin errors++; $display("FAIL row @%0d,%0d: got %0d expected %0d", cur_h, cur_v, bus.row, cur_v - (VS + VB)); end
        checks++; if (bus.rgb_out !== pix(cur_h, cur_v)) begin errors++; $display("FAIL rgb_out @%0d,%0d: got %0h expected %0h", cur_h, cur_v, bus.rgb_out, pix(cur_h, cur_v)); end
      end else begin
        checks++; if (bus.rgb_out !== 12'd0) begin errors++; $display("FAIL rgb_blank @%0d,%0d: got %0h expected 0", cur_h, cur_v, bus.rgb_out); end
      end
      if (bus.probe_hit) begin
        hits++;
        checks++; if (cur_h != 10 || cur_v != 6) begin errors++; $display("FAIL probe_pos: hit at sample %0d,%0d expected 10,6", cur_h, cur_v); end
      end
    end
    checks++; if (hits != 1) begin errors++; $display("FAIL probe_hits: got %0d expected 1", hits); end
    checks++; if (bus.probe_rgb !== pix(10, 6)) begin errors++; $display("FAIL probe_rgb: got %0h expected %0h", bus.probe_rgb, pix(10, 6)); end
  endtask

  task automatic test_stretch();
    int hits = 0, n_unlk = 0;
    bit done = 1'b0;
    bus.probe_col = 10'd0;
    bus.probe_row = 10'd0;
    stretch_line = 5;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (cur_h == 0 && cur_v == 6) done = 1'b1;
      else begin
        if (!bus.locked) n_unlk++;
        if (bus.probe_hit) hits++;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL stretch_timeout: line 6 start not reached, expected within 400 cycles"); end
    checks++; if (n_unlk != 0) begin errors++; $display("FAIL stretch_early_unlock: %0d unlocked cycles expected 0", n_unlk); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL stretch_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.err_cnt !== 8'd1) begin errors++; $display("FAIL stretch_err_cnt: got %0d expected 1", bus.err_cnt); end
    checks++; if (hits != 1) begin errors++; $display("FAIL probe00_hits: got %0d expected 1", hits); end
    checks++; if (bus.probe_rgb !== pix(7, 4)) begin errors++; $display("FAIL probe00_rgb: got %0h expected %0h", bus.probe_rgb, pix(7, 4)); end
    test_relock("stretch");
  endtask

  task automatic test_drop_line();
    bit got;
    logic pre;
    drop_frame = 1'b1;
    run_to_fs(got, pre);
    checks++; if (pre !== 1'b1) begin errors++; $display("FAIL drop_pre_locked: got %0b expected 1", pre); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL drop_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.err_cnt !== 8'd2) begin errors++; $display("FAIL drop_err_cnt: got %0d expected 2", bus.err_cnt); end
    test_relock("drop");
  endtask

  task automatic test_rst_mid_line();
    bit found = 1'b0, got;
    logic pre;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      found = bus.de && (cur_h == 11);
    end
    checks++; if (!found) begin errors++; $display("FAIL rst_mid_find: de=%0b at col 4 not seen, expected 1", bus.de); end
    rst = 1'b1;
    step();
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_mid_locked: got %0b expected 0", bus.locked); end
    checks++; if (bus.de !== 1'b0) begin errors++; $display("FAIL rst_mid_de: got %0b expected 0", bus.de); end
    checks++; if (bus.err_cnt !== 8'd0) begin errors++; $display("FAIL rst_mid_err_cnt: got %0d expected 0", bus.err_cnt); end
    checks++; if ({bus.col, bus.row} !== 20'd0) begin errors++; $display("FAIL rst_mid_colrow: got %0d,%0d expected 0,0", bus.col, bus.row); end
    checks++; if (bus.probe_rgb !== 12'd0) begin errors++; $display("FAIL rst_mid_probe_rgb: got %0h expected 0", bus.probe_rgb); end
    checks++; if ({bus.rgb_out, bus.frame_start, bus.probe_hit} !== 14'd0) begin errors++; $display("FAIL rst_mid_misc: rgb_out=%0h fs=%0b hit=%0b expected 0", bus.rgb_out, bus.frame_start, bus.probe_hit); end
    rst = 1'b0;
    run_to_fs(got, pre);
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL rst_mid_search: locked=%0b at first frame_start expected 0", bus.locked); end
  endtask

  task automatic test_tie_high();
    int n_fs = 0, n_lk = 0, n_de = 0;
    tie_high = 1'b1;
    repeat (2100) begin
      step();
      if (bus.frame_start) n_fs++;
      if (bus.locked) n_lk++;
      if (bus.de) n_de++;
    end
    checks++; if (n_fs != 0) begin errors++; $display("FAIL tie_fs: got %0d pulses expected 0", n_fs); end
    checks++; if (n_lk != 0) begin errors++; $display("FAIL tie_locked: got %0d cycles expected 0", n_lk); end
    checks++; if (n_de != 0) begin errors++; $display("FAIL tie_de: got %0d cycles expected 0", n_de); end
    checks++; if (dut.u_h_cnt.cnt !== 11'd2047) begin errors++; $display("FAIL tie_h_cnt: got %0d expected 2047", dut.u_h_cnt.cnt); end
  endtask

  initial begin
    bus.hsync     = 1'b1;
    bus.vsync     = 1'b1;
    bus.rgb       = 12'd0;
    bus.probe_col = 10'd0;
    bus.probe_row = 10'd0;
    test_reset();
    test_lock();
    test_display_probe();
    test_stretch();
    test_drop_line();
    test_rst_mid_line();
    test_tie_high();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
